// File: rtl/ex_md_unit.sv
// RV32M multiply/divide unit for the EX stage: single-cycle-array multiply,
// radix-2 restoring divide, stall request toward ID/EX and a registered result.
package milano_pkg;
    typedef enum logic [3:0] {
        MD_OP_NONE   = 4'd0,
        MD_OP_MUL    = 4'd1,
        MD_OP_MULH   = 4'd2,
        MD_OP_MULHSU = 4'd3,
        MD_OP_MULHU  = 4'd4,
        MD_OP_DIV    = 4'd5,
        MD_OP_DIVU   = 4'd6,
        MD_OP_REM    = 4'd7,
        MD_OP_REMU   = 4'd8
    } md_opt_e;
endpackage

module ex_md_unit
    import milano_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        md_sel_i,
    input  md_opt_e     md_operate_i,
    input  logic [31:0] md_operand_a_i,
    input  logic [31:0] md_operand_b_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        md_busy_o,
    output logic        md_valid_o,
    output logic [31:0] md_result_o,
    output logic [4:0]  md_rd_addr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
        return neg_if(v, sgn & v[31]);
    endfunction

    md_state_e   state_r;
    md_opt_e     op_r;
    logic [32:0] a_ext_r, b_ext_r;
    logic [31:0] quo_r, rem_r, dvs_r;
    logic        neg_q_r, neg_r_r;
    logic [4:0]  cnt_r;
    logic [31:0] result_r;
    logic [4:0]  rd_addr_r;

    logic        start_s, is_mul_s, is_div_s, sdiv_s, is_rem_s;
    logic        a_sgn_s, b_sgn_s, div_zero_s, div_ovf_s, special_s;
    logic [31:0] special_res_s;
    logic [63:0] prod_s;
    logic [32:0] trial_s;
    logic [31:0] nxt_rem_s, nxt_quo_s, div_res_s;

    // Decode the op presented by ID/EX and resolve divide special cases up front
    always_comb begin
        is_mul_s = (md_operate_i == MD_OP_MUL)  || (md_operate_i == MD_OP_MULH) ||
                   (md_operate_i == MD_OP_MULHSU) || (md_operate_i == MD_OP_MULHU);
        is_div_s = (md_operate_i == MD_OP_DIV)  || (md_operate_i == MD_OP_DIVU) ||
                   (md_operate_i == MD_OP_REM)  || (md_operate_i == MD_OP_REMU);
        sdiv_s   = (md_operate_i == MD_OP_DIV)  || (md_operate_i == MD_OP_REM);
        is_rem_s = (md_operate_i == MD_OP_REM)  || (md_operate_i == MD_OP_REMU);
        a_sgn_s  = (md_operate_i == MD_OP_MULH) || (md_operate_i == MD_OP_MULHSU);
        b_sgn_s  = (md_operate_i == MD_OP_MULH);
        div_zero_s = (md_operand_b_i == 32'd0);
        div_ovf_s  = sdiv_s && (md_operand_a_i == 32'h8000_0000) &&
                     (md_operand_b_i == 32'hFFFF_FFFF);
        special_s  = is_div_s && (div_zero_s || div_ovf_s);
        if (div_zero_s) begin
            special_res_s = is_rem_s ? md_operand_a_i : 32'hFFFF_FFFF;
        end else begin
            special_res_s = is_rem_s ? 32'd0 : 32'h8000_0000;
        end
        start_s = (state_r == ST_IDLE) && md_sel_i && (md_operate_i != MD_OP_NONE) && !flush_i;
    end

    // Datapath for the multiply product and one restoring-divide step
    always_comb begin
        prod_s  = $signed({{31{a_ext_r[32]}}, a_ext_r}) * $signed({{31{b_ext_r[32]}}, b_ext_r});
        trial_s = {rem_r, quo_r[31]} - {1'b0, dvs_r};
        if (trial_s[32]) begin
            nxt_rem_s = {rem_r[30:0], quo_r[31]};
            nxt_quo_s = {quo_r[30:0], 1'b0};
        end else begin
            nxt_rem_s = trial_s[31:0];
            nxt_quo_s = {quo_r[30:0], 1'b1};
        end
        if ((op_r == MD_OP_REM) || (op_r == MD_OP_REMU)) begin
            div_res_s = neg_if(nxt_rem_s, neg_r_r);
        end else begin
            div_res_s = neg_if(nxt_quo_s, neg_q_r);
        end
    end

    // Control FSM with operand capture and result register; flush wins over everything
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            op_r      <= MD_OP_NONE;
            a_ext_r   <= 33'd0;
            b_ext_r   <= 33'd0;
            quo_r     <= 32'd0;
            rem_r     <= 32'd0;
            dvs_r     <= 32'd0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            cnt_r     <= 5'd0;
            result_r  <= 32'd0;
            rd_addr_r <= 5'd0;
        end else if (flush_i) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        op_r      <= md_operate_i;
                        rd_addr_r <= rd_addr_i;
                        cnt_r     <= 5'd0;
                        if (special_s) begin
                            result_r <= special_res_s;
                            state_r  <= ST_DONE;
                        end else if (is_mul_s) begin
                            a_ext_r <= {a_sgn_s & md_operand_a_i[31], md_operand_a_i};
                            b_ext_r <= {b_sgn_s & md_operand_b_i[31], md_operand_b_i};
                            state_r <= ST_MUL;
                        end else begin
                            quo_r   <= abs_if(md_operand_a_i, sdiv_s);
                            dvs_r   <= abs_if(md_operand_b_i, sdiv_s);
                            rem_r   <= 32'd0;
                            neg_q_r <= sdiv_s & (md_operand_a_i[31] ^ md_operand_b_i[31]);
                            neg_r_r <= sdiv_s & md_operand_a_i[31];
                            state_r <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    result_r <= (op_r == MD_OP_MUL) ? prod_s[31:0] : prod_s[63:32];
                    state_r  <= ST_DONE;
                end
                ST_DIV: begin
                    rem_r <= nxt_rem_s;
                    quo_r <= nxt_quo_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        result_r <= div_res_s;
                        state_r  <= ST_DONE;
                    end
                end
                // The DONE-cycle inputs are the same instruction still in ID/EX
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign md_busy_o    = start_s || (state_r == ST_MUL) || (state_r == ST_DIV);
    assign md_valid_o   = (state_r == ST_DONE) && !flush_i;
    assign md_result_o  = result_r;
    assign md_rd_addr_o = rd_addr_r;

endmodule

// File: tb/tb_ex_md_unit.sv
// Scoreboard bench for ex_md_unit: directed RV32M vectors, flush and reset cases.
module tb_ex_md_unit;
    import milano_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        md_sel_i;
    md_opt_e     md_operate_i;
    logic [31:0] md_operand_a_i, md_operand_b_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        md_busy_o, md_valid_o;
    logic [31:0] md_result_o;
    logic [4:0]  md_rd_addr_o;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    ex_md_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .md_sel_i(md_sel_i), .md_operate_i(md_operate_i),
        .md_operand_a_i(md_operand_a_i), .md_operand_b_i(md_operand_b_i),
        .rd_addr_i(rd_addr_i), .flush_i(flush_i), .md_busy_o(md_busy_o),
        .md_valid_o(md_valid_o), .md_result_o(md_result_o), .md_rd_addr_o(md_rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: every valid strobe must match the oldest outstanding expectation
    always @(negedge clk_i) begin
        if (md_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result 0x%08h at cycle %0d, expected no valid",
                         md_result_o, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", md_result_o, e.res);
                chk("rd_addr", {27'd0, md_rd_addr_o}, {27'd0, e.rd});
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input md_opt_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int busy_n;
        bit done;
        @(posedge clk_i); #1;
        md_sel_i = 1'b1;
        md_operate_i = op;
        md_operand_a_i = a;
        md_operand_b_i = b;
        rd_addr_i = rd;
        sb_q.push_back('{res: exp, rd: rd, cyc: cyc + lat});
        busy_n = 0;
        done = 1'b0;
        // ID/EX holds the instruction while busy and for the DONE cycle
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (md_busy_o) busy_n++;
            else done = 1'b1;
            @(posedge clk_i); #1;
        end
        chk("busy_cycles", busy_n, lat);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy still high after 40 cycles, expected release");
        end
        md_sel_i = 1'b0;
        md_operate_i = MD_OP_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        md_sel_i = 1'b0;
        md_operate_i = MD_OP_NONE;
        md_operand_a_i = 32'd0;
        md_operand_b_i = 32'd0;
        rd_addr_i = 5'd0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", {31'd0, md_busy_o}, 32'd0);
        chk("rst_valid", {31'd0, md_valid_o}, 32'd0);
        chk("rst_result", md_result_o, 32'd0);
        chk("rst_rd", {27'd0, md_rd_addr_o}, 32'd0);
        rst_ni = 1'b1;

        issue(MD_OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 2);
        issue(MD_OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 2);
        issue(MD_OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 2);
        issue(MD_OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd6,  32'hFFFF_FFFF, 2);
        issue(MD_OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd7,  32'h4000_0000, 2);
        issue(MD_OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFD, 33);
        issue(MD_OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFF, 33);
        issue(MD_OP_DIVU,   32'd100,        32'd7,         5'd10, 32'd14,        33);
        issue(MD_OP_REMU,   32'd100,        32'd7,         5'd11, 32'd2,         33);
        issue(MD_OP_DIVU,   32'd5,          32'd0,         5'd12, 32'hFFFF_FFFF, 1);
        issue(MD_OP_REM,    32'd5,          32'd0,         5'd13, 32'd5,         1);
        issue(MD_OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
        issue(MD_OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'd0,         1);

        // MD_OP_NONE with md_sel_i high must not start or stall
        @(posedge clk_i); #1;
        md_sel_i = 1'b1;
        md_operate_i = MD_OP_NONE;
        #1;
        chk("none_busy", {31'd0, md_busy_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        md_sel_i = 1'b0;

        // Flush beats start in the same cycle
        md_sel_i = 1'b1;
        md_operate_i = MD_OP_MUL;
        md_operand_a_i = 32'd3;
        md_operand_b_i = 32'd3;
        flush_i = 1'b1;
        #1;
        chk("flush_start_busy", {31'd0, md_busy_o}, 32'd0);
        @(posedge clk_i); #1;
        md_sel_i = 1'b0;
        md_operate_i = MD_OP_NONE;
        flush_i = 1'b0;
        #1;
        chk("flush_start_idle", {31'd0, md_busy_o}, 32'd0);

        // Flush a divide at iteration 10
        @(posedge clk_i); #1;
        md_sel_i = 1'b1;
        md_operate_i = MD_OP_DIV;
        md_operand_a_i = 32'd1000;
        md_operand_b_i = 32'd3;
        rd_addr_i = 5'd20;
        repeat (11) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        md_sel_i = 1'b0;
        md_operate_i = MD_OP_NONE;
        #1;
        chk("flush_div_busy", {31'd0, md_busy_o}, 32'd0);
        repeat (40) @(posedge clk_i);
        issue(MD_OP_MUL, 32'd6, 32'd7, 5'd21, 32'd42, 2);

        // Asynchronous reset in the middle of a divide
        @(posedge clk_i); #1;
        md_sel_i = 1'b1;
        md_operate_i = MD_OP_DIVU;
        md_operand_a_i = 32'd999;
        md_operand_b_i = 32'd4;
        rd_addr_i = 5'd22;
        repeat (5) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        md_sel_i = 1'b0;
        md_operate_i = MD_OP_NONE;
        #1;
        chk("midrst_busy", {31'd0, md_busy_o}, 32'd0);
        chk("midrst_valid", {31'd0, md_valid_o}, 32'd0);
        chk("midrst_result", md_result_o, 32'd0);
        chk("midrst_rd", {27'd0, md_rd_addr_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (40) @(posedge clk_i);
        issue(MD_OP_REMU, 32'd999, 32'd4, 5'd23, 32'd3, 33);

        repeat (3) @(posedge clk_i);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
